// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory port arbiter:
//   - arb_state_e : sequencing FSM states (IDLE / BUSY / RESP)
//   - arb_owner_e : which requester owns the in-flight transaction
//   - default widths and streak limit used by mem_port_arbiter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MAX_D_STREAK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_streak_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_streak_cnt
// Saturating counter of consecutive D grants taken while I was waiting.
// Clear has priority over increment; the count never exceeds MAX_COUNT.
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_inc      count one more D grant
//   i_clr      return the count to zero
//   o_count    current count
//   o_at_limit count has reached MAX_COUNT
// -----------------------------------------------------------------------------
module mem_arb_streak_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_COUNT = DEF_MAX_D_STREAK
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_inc,
    input  logic                             i_clr,
    output logic [$clog2(MAX_COUNT+1)-1:0]   o_count,
    output logic                             o_at_limit
);

    localparam int                 CNT_W = $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0]   LIMIT = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] r_count;

    // Streak count register: clear wins, increment saturates at LIMIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_inc && (r_count < LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = (r_count >= LIMIT);

endmodule : mem_arb_streak_cnt

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one variable-latency single-port memory between instruction fetch (I)
// and the MEM-stage data port (D). A request is granted only in IDLE, captured,
// driven to memory in BUSY until mem_ack_i, and completed with a one-cycle
// ready pulse in RESP. D wins by default; after MAX_D_STREAK consecutive D
// grants taken while I was waiting, I is granted.
// Ports:
//   clk_i, rst_i                 clock / asynchronous active-low reset
//   i_req_i, i_addr_i            fetch request (held until i_ready_o)
//   i_rdata_o, i_ready_o         fetched word and its completion pulse
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                    data request (held until d_ready_o)
//   d_rdata_o, d_ready_o         load data and its completion pulse
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o      memory request side, held until mem_ack_i
//   mem_rdata_i, mem_ack_i       memory completion side
//   stall_o                      pipeline stall (only combinational output)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    arb_owner_e           r_owner;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic                 r_i_ready;
    logic                 r_d_ready;
    logic [DATA_W-1:0]    r_i_rdata;
    logic [DATA_W-1:0]    r_d_rdata;

    logic                 w_grant_d;
    logic                 w_grant_i;
    logic                 w_streak_inc;
    logic                 w_streak_clr;
    logic                 w_at_limit;
    logic [STREAK_W-1:0]  w_streak;

    logic                 w_load;
    logic                 w_mem_req_nxt;
    logic                 w_mem_we_nxt;
    logic                 w_i_ready_nxt;
    logic                 w_d_ready_nxt;
    logic                 w_i_cap;
    logic                 w_d_cap;

    // Grant decision, meaningful only while IDLE: D unless I has waited too long
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == IDLE) begin
            w_grant_d = d_req_i & (~i_req_i | ~w_at_limit);
            w_grant_i = i_req_i & ~w_grant_d;
        end else begin
            w_grant_d = 1'b0;
            w_grant_i = 1'b0;
        end
    end

    // Streak bookkeeping: count D grants that made I wait, clear once I is not waiting
    assign w_streak_inc = w_grant_d & i_req_i;
    assign w_streak_clr = (r_state == IDLE) & (w_grant_i | ~i_req_i);

    mem_arb_streak_cnt #(
        .MAX_COUNT (MAX_D_STREAK)
    ) u_streak_cnt (
        .i_clk      (clk_i),
        .i_rst_n    (rst_i),
        .i_inc      (w_streak_inc),
        .i_clr      (w_streak_clr),
        .o_count    (w_streak),
        .o_at_limit (w_at_limit)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d || w_grant_i) begin
                    w_state_nxt = BUSY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs and capture strobes
    always_comb begin
        w_load        = 1'b0;
        w_mem_req_nxt = 1'b0;
        w_mem_we_nxt  = 1'b0;
        w_i_ready_nxt = 1'b0;
        w_d_ready_nxt = 1'b0;
        w_i_cap       = 1'b0;
        w_d_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_d || w_grant_i) begin
                    w_load        = 1'b1;
                    w_mem_req_nxt = 1'b1;
                    w_mem_we_nxt  = w_grant_d & d_we_i;
                end else begin
                    w_load        = 1'b0;
                    w_mem_req_nxt = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    w_i_ready_nxt = (r_owner == OWN_I);
                    w_d_ready_nxt = (r_owner == OWN_D);
                    w_i_cap       = (r_owner == OWN_I);
                    // stores leave the D read-data register untouched
                    w_d_cap       = (r_owner == OWN_D) & ~r_mem_we;
                end else begin
                    w_mem_req_nxt = 1'b1;
                    w_mem_we_nxt  = r_mem_we;
                end
            end
            RESP: begin
                w_mem_req_nxt = 1'b0;
            end
            default: begin
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Request capture: owner, address and write data frozen for the whole BUSY phase
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_owner <= OWN_I;
            r_addr  <= {ADDR_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
        end else if (w_load) begin
            r_owner <= w_grant_d ? OWN_D : OWN_I;
            r_addr  <= w_grant_d ? d_addr_i : i_addr_i;
            r_wdata <= w_grant_d ? d_wdata_i : {DATA_W{1'b0}};
        end else begin
            r_owner <= r_owner;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Registered handshake outputs toward memory and requesters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
        end else begin
            r_mem_req <= w_mem_req_nxt;
            r_mem_we  <= w_mem_we_nxt;
            r_i_ready <= w_i_ready_nxt;
            r_d_ready <= w_d_ready_nxt;
        end
    end

    // Read-data holding registers, each updated only by its own port's completion
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_i_rdata <= {DATA_W{1'b0}};
            r_d_rdata <= {DATA_W{1'b0}};
        end else begin
            r_i_rdata <= w_i_cap ? mem_rdata_i : r_i_rdata;
            r_d_rdata <= w_d_cap ? mem_rdata_i : r_d_rdata;
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign i_ready_o   = r_i_ready;
    assign d_ready_o   = r_d_ready;
    assign i_rdata_o   = r_i_rdata;
    assign d_rdata_o   = r_d_rdata;

    assign stall_o = (i_req_i & ~r_i_ready) | (d_req_i & ~r_d_ready);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: memory handshake is driven by hand, and
// every expected value is written out in the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_rdata_o;
    logic        i_ready_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_D_STREAK (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_req_i     (i_req_i),
        .i_addr_i    (i_addr_i),
        .i_rdata_o   (i_rdata_o),
        .i_ready_o   (i_ready_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_ready_o   (d_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From an IDLE cycle with requests already raised: grant, ack after one
    // BUSY cycle with data rd, check the ready pulse and the return to IDLE.
    task automatic do_txn(input string tag, input logic [31:0] exp_addr,
                          input logic exp_we, input logic [31:0] rd, input logic is_d);
        tick();
        chk({tag, " mem_req"},  {31'd0, mem_req_o}, 32'd1);
        chk({tag, " mem_addr"}, mem_addr_o, exp_addr);
        chk({tag, " mem_we"},   {31'd0, mem_we_o}, {31'd0, exp_we});
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
        tick();
        mem_ack_i   = 1'b0;
        chk({tag, " d_ready"},  {31'd0, d_ready_o}, {31'd0, is_d});
        chk({tag, " i_ready"},  {31'd0, i_ready_o}, {31'd0, ~is_d});
        chk({tag, " req_drop"}, {31'd0, mem_req_o}, 32'd0);
        if (!exp_we) begin
            chk({tag, " rdata"}, is_d ? d_rdata_o : i_rdata_o, rd);
        end
        tick();
        chk({tag, " ready_once"}, {30'd0, i_ready_o, d_ready_o}, 32'd0);
    endtask

    initial begin
        rst_i       = 1'b0;
        i_req_i     = 1'b0;
        i_addr_i    = 32'h0;
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_addr_i    = 32'h0;
        d_wdata_i   = 32'h0;
        mem_rdata_i = 32'h0;
        mem_ack_i   = 1'b0;

        // ---- reset state ----
        tick(); tick(); tick();
        chk("rst mem_req",   {31'd0, mem_req_o}, 32'd0);
        chk("rst mem_we",    {31'd0, mem_we_o}, 32'd0);
        chk("rst mem_addr",  mem_addr_o, 32'h0);
        chk("rst mem_wdata", mem_wdata_o, 32'h0);
        chk("rst readies",   {30'd0, i_ready_o, d_ready_o}, 32'd0);
        chk("rst rdata",     i_rdata_o | d_rdata_o, 32'h0);
        rst_i = 1'b1;
        tick();
        chk("idle stall", {31'd0, stall_o}, 32'd0);

        // ---- single I fetch, ack in the first BUSY cycle ----
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_0040;
        #1;
        chk("if stall c0", {31'd0, stall_o}, 32'd1);
        tick();
        chk("if mem_req c1", {31'd0, mem_req_o}, 32'd1);
        chk("if mem_we c1",  {31'd0, mem_we_o}, 32'd0);
        chk("if addr c1",    mem_addr_o, 32'h0000_0040);
        chk("if stall c1",   {31'd0, stall_o}, 32'd1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h2002_0005;
        tick();
        mem_ack_i = 1'b0;
        chk("if ready c2", {31'd0, i_ready_o}, 32'd1);
        chk("if rdata c2", i_rdata_o, 32'h2002_0005);
        chk("if stall c2", {31'd0, stall_o}, 32'd0);
        i_req_i = 1'b0;
        tick();
        chk("if ready c3", {31'd0, i_ready_o}, 32'd0);
        chk("if rdata hold", i_rdata_o, 32'h2002_0005);

        // ---- simultaneous I and D loads: D first, then I ----
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_0200;
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h0000_0100;
        do_txn("sim D", 32'h0000_0100, 1'b0, 32'h1111_1111, 1'b1);
        d_req_i = 1'b0;
        do_txn("sim I", 32'h0000_0200, 1'b0, 32'h2222_2222, 1'b0);
        i_req_i = 1'b0;
        tick();

        // ---- D held with I waiting: D,D,D,D,I then D again (streak cleared) ----
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_0400;
        d_req_i  = 1'b1;
        d_addr_i = 32'h0000_0300;
        do_txn("stk D0", 32'h0000_0300, 1'b0, 32'h1000_0000, 1'b1);
        do_txn("stk D1", 32'h0000_0300, 1'b0, 32'h1000_0001, 1'b1);
        do_txn("stk D2", 32'h0000_0300, 1'b0, 32'h1000_0002, 1'b1);
        do_txn("stk D3", 32'h0000_0300, 1'b0, 32'h1000_0003, 1'b1);
        do_txn("stk I4", 32'h0000_0400, 1'b0, 32'h1000_0004, 1'b0);
        do_txn("stk D5", 32'h0000_0300, 1'b0, 32'h1000_0005, 1'b1);
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        tick();

        // ---- D store with ack delayed to the fifth BUSY cycle ----
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h0000_0010;
        d_wdata_i = 32'hDEAD_BEEF;
        tick();
        d_addr_i  = 32'hFFFF_FFF0;
        d_wdata_i = 32'h0BAD_0BAD;
        d_we_i    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("st mem_req",   {31'd0, mem_req_o}, 32'd1);
            chk("st mem_we",    {31'd0, mem_we_o}, 32'd1);
            chk("st mem_addr",  mem_addr_o, 32'h0000_0010);
            chk("st mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            chk("st no ready",  {31'd0, d_ready_o}, 32'd0);
            if (i == 4) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hCAFE_F00D;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        chk("st d_ready", {31'd0, d_ready_o}, 32'd1);
        chk("st rdata kept", d_rdata_o, 32'h1000_0005);
        chk("st we drop", {31'd0, mem_we_o}, 32'd0);
        d_req_i = 1'b0;
        tick();
        chk("st ready once", {31'd0, d_ready_o}, 32'd0);

        // ---- reset during BUSY, late ack ignored, fresh request works ----
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_0080;
        tick();
        chk("rb busy", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        chk("rb req drop", {31'd0, mem_req_o}, 32'd0);
        chk("rb addr clr", mem_addr_o, 32'h0);
        i_req_i = 1'b0;
        tick();
        rst_i       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        tick();
        mem_ack_i = 1'b0;
        chk("rb late ack", {30'd0, i_ready_o, d_ready_o}, 32'd0);
        chk("rb no req",   {31'd0, mem_req_o}, 32'd0);
        chk("rb rdata",    i_rdata_o, 32'h0);
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_0084;
        do_txn("rb fresh", 32'h0000_0084, 1'b0, 32'h0000_0055, 1'b0);
        i_req_i = 1'b0;
        tick();

        // ---- spurious ack in IDLE ----
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h9999_9999;
        tick();
        mem_ack_i = 1'b0;
        chk("sp readies", {30'd0, i_ready_o, d_ready_o}, 32'd0);
        chk("sp mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("sp i_rdata", i_rdata_o, 32'h0000_0055);
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h0000_0500;
        do_txn("sp after", 32'h0000_0500, 1'b0, 32'h3333_3333, 1'b1);
        d_req_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter that shares one variable-latency, single-port memory between the pipeline's instruction-fetch requester (I) and MEM-stage data requester (D). Captures each granted request, drives the memory handshake until acknowledged, returns read data with a one-cycle ready pulse, and raises a stall to the pipeline while any request is outstanding. D wins by default; a streak counter guarantees I forward progress.

## Interface
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive D grants allowed while I waits; range 1..15

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- i_req_i  in  1  fetch request, held until i_ready_o
- i_addr_i  in  ADDR_W  fetch address
- i_rdata_o  out  DATA_W  fetched instruction, valid with i_ready_o
- i_ready_o  out  1  one-cycle completion pulse for I
- d_req_i  in  1  data request, held until d_ready_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data, valid with d_ready_o
- d_ready_o  out  1  one-cycle completion pulse for D
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, one cycle
- stall_o  out  1  combinational: (i_req_i & ~i_ready_o) | (d_req_i & ~d_ready_o)

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: grant only here. D granted if d_req_i & (~i_req_i | streak < MAX_D_STREAK); else I granted if i_req_i. No request: stay IDLE. On grant, latch owner, addr, we (I: we=0), wdata into capture registers, go BUSY.
- BUSY: mem_req_o=1, mem_* driven from capture registers (stable). Requester input changes ignored. On mem_ack_i: capture mem_rdata_i into owner's rdata register (stores: rdata register unchanged), go RESP.
- RESP: owner's ready_o=1 for exactly this cycle; no grant; next state IDLE. Requester must drop or change its request after the ready pulse; a request still high in the following IDLE is treated as new.
- Streak counter: on D grant with i_req_i=1, increment (saturate at MAX_D_STREAK); on I grant, or any IDLE cycle with i_req_i=0, clear.
- mem_ack_i outside BUSY ignored (no state change, no data capture).
- Reset (any cycle, including BUSY): state IDLE, streak 0, mem_req_o/mem_we_o/i_ready_o/d_ready_o 0, all addr/data outputs 0; in-flight memory transaction abandoned, late ack ignored.

## Timing
- Request high in IDLE at cycle 0 -> mem_req_o high from cycle 1 -> ack at cycle k (k>=1) -> ready pulse at k+1 -> IDLE at k+2.
- Minimum request-to-ready latency 2 cycles; minimum issue interval 3 cycles.
- rdata_o holds last value until next capture for the same port.
- stall_o is the only combinational path input-to-output; all other outputs registered.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE=2'b00, BUSY=2'b01, RESP=2'b10), owner encoding (OWN_I=1'b0, OWN_D=1'b1), default widths.
- One sub-module natural: mem_arb_streak_cnt (saturating counter with clear, width $clog2(MAX_D_STREAK+1)), emitting at_limit.

## Test plan
- Single I fetch, addr 0x0000_0040, memory acks 1 cycle after mem_req_o -> mem_we_o=0, i_rdata_o=0x2002_0005 with i_ready_o 2 cycles after request; stall_o high until that cycle.
- Simultaneous I and D load requests -> D served first, I granted in IDLE after D's RESP; both ready pulses once.
- D held continuously with I waiting, MAX_D_STREAK=4 -> grants D,D,D,D,I; streak clears after I grant.
- D store addr 0x10, wdata 0xDEAD_BEEF, ack delayed 5 cycles -> mem_* stable for all 5 BUSY cycles; d_ready_o 1 cycle after ack; d_rdata_o unchanged.
- Reset asserted during BUSY -> mem_req_o drops immediately; subsequent mem_ack_i produces no ready pulse; fresh request afterward completes normally.
- Spurious mem_ack_i in IDLE -> no ready, no state change.
